// File: rtl/data_upload.sv
// data_upload: streams bytes from a core-side RAM to the io controller over the data-io SPI link.
// SPI pins are sampled in clk; 0x55 <nonzero> opens a session, 0x56 clocks RAM bytes out on sdo.
module data_upload #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 16'd0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  sdo_oe,
    input  logic [ADDR_WIDTH-1:0] size,
    output logic                  uploading,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] a,
    input  logic [7:0]            q
);

    localparam logic [7:0] CMD_FILE_RX     = 8'h55;
    localparam logic [7:0] CMD_FILE_RX_DAT = 8'h56;

    logic [2:0]            sck_sync_q;
    logic [1:0]            ss_sync_q;
    logic [1:0]            sdi_sync_q;

    logic [3:0]            cnt_q, cnt_d;
    logic [6:0]            sbuf_q, sbuf_d;
    logic [7:0]            cmd_q, cmd_d;
    logic                  uploading_q, uploading_d;
    logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic                  rd_q, rd_d;
    logic                  rd_dly_q, rd_dly_d;
    logic [7:0]            pbuf_q, pbuf_d;
    logic                  pvalid_q, pvalid_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  sdo_q, sdo_d;
    logic                  sdo_oe_q, sdo_oe_d;

    logic                  ss_s;
    logic                  sdi_s;
    logic                  sck_rise;
    logic                  spi_bit;
    logic [7:0]            byte_in;
    logic                  start_evt;
    logic                  load_evt;
    logic                  shift_evt;
    logic                  can_load;
    logic [ADDR_WIDTH-1:0] a_inc;

    assign ss_s     = ss_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign spi_bit  = sck_rise & ~ss_s;
    assign byte_in  = {sbuf_q, sdi_s};

    // Byte boundaries: command completion at cnt 7, then the end of every data byte.
    assign start_evt = spi_bit && (cnt_q == 4'd15) && (cmd_q == CMD_FILE_RX);
    assign load_evt  = spi_bit && (((cnt_q == 4'd7) && (byte_in == CMD_FILE_RX_DAT)) ||
                                   ((cnt_q == 4'd15) && (cmd_q == CMD_FILE_RX_DAT)));
    assign shift_evt = spi_bit && cnt_q[3] && (cmd_q == CMD_FILE_RX_DAT) && !load_evt;
    assign can_load  = uploading_q && pvalid_q && (a_q != end_addr_q);
    assign a_inc     = a_q + ADDR_WIDTH'(1);

    always_comb begin
        cnt_d       = cnt_q;
        sbuf_d      = sbuf_q;
        cmd_d       = cmd_q;
        uploading_d = uploading_q;
        end_addr_d  = end_addr_q;
        a_d         = a_q;
        rd_d        = 1'b0;
        rd_dly_d    = rd_q;
        pbuf_d      = pbuf_q;
        pvalid_d    = pvalid_q;
        shreg_d     = shreg_q;

        if (ss_s) begin
            cnt_d = 4'd0;
        end else if (sck_rise) begin
            sbuf_d = byte_in[6:0];
            cnt_d  = (cnt_q == 4'd15) ? 4'd8 : cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
                cmd_d = byte_in;
            end
        end

        if (rd_dly_q) begin
            pbuf_d   = q;
            pvalid_d = 1'b1;
        end

        // A start or stop also cancels any read still in flight from the old session.
        if (start_evt) begin
            pvalid_d = 1'b0;
            rd_dly_d = 1'b0;
            if (byte_in != 8'h00) begin
                uploading_d = 1'b1;
                end_addr_d  = START_ADDR + size;
                a_d         = START_ADDR;
                rd_d        = (size != '0);
            end else begin
                uploading_d = 1'b0;
            end
        end

        if (load_evt) begin
            if (can_load) begin
                shreg_d  = pbuf_q;
                pvalid_d = 1'b0;
                a_d      = a_inc;
                rd_d     = (a_inc != end_addr_q);
            end else begin
                shreg_d = 8'h00;
            end
        end else if (shift_evt) begin
            shreg_d = {shreg_q[6:0], 1'b0};
        end

        sdo_oe_d = !ss_s && (cmd_q == CMD_FILE_RX_DAT) && cnt_q[3];
        sdo_d    = sdo_oe_d & shreg_q[7];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= 3'b000;
            ss_sync_q   <= 2'b11;
            sdi_sync_q  <= 2'b00;
            cnt_q       <= 4'd0;
            sbuf_q      <= 7'd0;
            cmd_q       <= 8'h00;
            uploading_q <= 1'b0;
            end_addr_q  <= START_ADDR;
            a_q         <= START_ADDR;
            rd_q        <= 1'b0;
            rd_dly_q    <= 1'b0;
            pbuf_q      <= 8'h00;
            pvalid_q    <= 1'b0;
            shreg_q     <= 8'h00;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], sck};
            ss_sync_q   <= {ss_sync_q[0], ss};
            sdi_sync_q  <= {sdi_sync_q[0], sdi};
            cnt_q       <= cnt_d;
            sbuf_q      <= sbuf_d;
            cmd_q       <= cmd_d;
            uploading_q <= uploading_d;
            end_addr_q  <= end_addr_d;
            a_q         <= a_d;
            rd_q        <= rd_d;
            rd_dly_q    <= rd_dly_d;
            pbuf_q      <= pbuf_d;
            pvalid_q    <= pvalid_d;
            shreg_q     <= shreg_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
        end
    end

    assign uploading = uploading_q;
    assign rd        = rd_q;
    assign a         = a_q;
    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;

endmodule

// File: tb/tb_data_upload.sv
// Bench for data_upload: acts as the SPI host and the RAM, checks MISO bytes, read strobes and state.
`timescale 1ns/1ps
module tb_data_upload;

    localparam logic [7:0] C_RX  = 8'h55;
    localparam logic [7:0] C_DAT = 8'h56;
    localparam logic [7:0] C_DL  = 8'h53;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sck;
    logic        ss;
    logic        sdi;
    logic        sdo;
    logic        sdo_oe;
    logic [15:0] size;
    logic        uploading;
    logic        rd;
    logic [15:0] a;
    logic [7:0]  q = 8'h00;

    data_upload #(.ADDR_WIDTH(16), .START_ADDR(16'd0)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .size(size), .uploading(uploading),
        .rd(rd), .a(a), .q(q)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [15:0] rd_log [$];
    int          b2b_cnt = 0;
    logic        rd_prev = 1'b0;

    always @(posedge clk) begin
        if (rd) begin
            q <= mem[a[7:0]];
            rd_log.push_back(a);
        end
    end

    always @(negedge clk) begin
        if (rd && rd_prev) b2b_cnt <= b2b_cnt + 1;
        rd_prev <= rd;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          jitter_on = 1'b0;

    // Reference model: session flag, next address to send, end address.
    bit          m_up = 1'b0;
    logic [15:0] m_addr = 16'd0;
    logic [15:0] m_end  = 16'd0;
    logic [7:0]  exp_q [$];
    logic [15:0] exp_rd [$];
    logic [7:0]  rx_q [$];
    int          rd_base = 0;

    typedef struct packed {
        logic [15:0] size;
        logic [31:0] ram;
        logic [7:0]  ndata;
        logic [31:0] exp;
        logic [7:0]  exp_rd;
        logic [15:0] exp_a;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_half();
        int n;
        n = jitter_on ? int'($urandom_range(4, 6)) : 6;
        repeat (n) @(negedge clk);
        if (jitter_on) #($urandom_range(0, 3));
    endtask

    // Host sampling happens just before each rising sck, matching the device's update timing.
    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso, output int oe_ones);
        miso    = 8'h00;
        oe_ones = 0;
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            sdi = mosi[7-i];
            wait_half();
            miso = {miso[6:0], sdo};
            if (sdo_oe) oe_ones++;
            sck = 1'b1;
            wait_half();
        end
        sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] param, input int ndata, input int npart);
        logic [7:0] b;
        int         ones;
        ss = 1'b0;
        wait_half();
        spi_bits(cmd, 8, b, ones);
        chk("cmd_byte_oe", 32'(ones), 32'd0);
        for (int k = 0; k < ndata; k++) begin
            spi_bits(param, 8, b, ones);
            if (cmd == C_DAT) begin
                chk("data_byte_oe", 32'(ones), 32'd8);
                rx_q.push_back(b);
            end else begin
                chk("other_byte_oe", 32'(ones), 32'd0);
            end
        end
        if (npart > 0) spi_bits(param, npart, b, ones);
        wait_half();
        ss = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_oe", 32'(sdo_oe), 32'd0);
        chk("idle_sdo", 32'(sdo), 32'd0);
    endtask

    // Every completed byte of a 0x56 transfer, plus the command byte, is one load.
    task automatic model_xfer(input logic [7:0] cmd, input logic [7:0] param, input int ndata);
        logic [7:0] v;
        if (cmd == C_RX) begin
            for (int k = 0; k < ndata; k++) begin
                if (param != 8'h00) begin
                    m_up   = 1'b1;
                    m_addr = 16'd0;
                    m_end  = size;
                    if (size != 16'd0) exp_rd.push_back(m_addr);
                end else begin
                    m_up = 1'b0;
                end
            end
        end else if (cmd == C_DAT) begin
            for (int k = 0; k <= ndata; k++) begin
                v = 8'h00;
                if (m_up && m_addr != m_end) begin
                    v      = mem[m_addr[7:0]];
                    m_addr = m_addr + 16'd1;
                    if (m_addr != m_end) exp_rd.push_back(m_addr);
                end
                if (k < ndata) exp_q.push_back(v);
            end
        end
    endtask

    task automatic run(input logic [7:0] cmd, input logic [7:0] param, input int ndata, input int npart);
        model_xfer(cmd, param, ndata);
        xfer(cmd, param, ndata, npart);
    endtask

    task automatic flush();
        rx_q.delete();
        exp_q.delete();
        exp_rd.delete();
        rd_base = rd_log.size();
    endtask

    task automatic compare_state(input string name);
        int nr;
        chk($sformatf("%s_nbytes", name), 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        nr = rd_log.size() - rd_base;
        chk($sformatf("%s_rd_count", name), 32'(nr), 32'(exp_rd.size()));
        for (int i = 0; i < nr && i < exp_rd.size(); i++)
            chk($sformatf("%s_rd_addr%0d", name, i), 32'(rd_log[rd_base+i]), 32'(exp_rd[i]));
        chk($sformatf("%s_a", name), 32'(a), 32'(m_addr));
        chk($sformatf("%s_uploading", name), 32'(uploading), 32'(m_up));
        flush();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         ones;
        int         nr;
        int         r;

        vecs[0] = '{16'd4, 32'hA53CFF01, 8'd4, 32'hA53CFF01, 8'd4, 16'd4};
        vecs[1] = '{16'd2, 32'h11223344, 8'd4, 32'h11220000, 8'd2, 16'd2};
        vecs[2] = '{16'd0, 32'h5A5A5A5A, 8'd2, 32'h00000000, 8'd0, 16'd0};
        vecs[3] = '{16'd1, 32'hC3E10F77, 8'd3, 32'hC3000000, 8'd1, 16'd1};
        vecs[4] = '{16'd3, 32'h01020304, 8'd1, 32'h01000000, 8'd3, 16'd2};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset_n = 1'b0;
        sck     = 1'b0;
        ss      = 1'b1;
        sdi     = 1'b0;
        size    = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_uploading", 32'(uploading), 32'd0);
        chk("reset_rd", 32'(rd), 32'd0);
        chk("reset_a", 32'(a), 32'd0);
        chk("reset_sdo", 32'(sdo), 32'd0);
        chk("reset_sdo_oe", 32'(sdo_oe), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) mem[j] = vecs[i].ram[31-8*j -: 8];
            size = vecs[i].size;
            run(C_RX, 8'h01, 1, 0);
            run(C_DAT, 8'h00, int'(vecs[i].ndata), 0);
            chk($sformatf("vec%0d_nbytes", i), 32'(rx_q.size()), 32'(vecs[i].ndata));
            for (int j = 0; j < rx_q.size() && j < 4; j++)
                chk($sformatf("vec%0d_byte%0d", i, j), 32'(rx_q[j]), 32'(vecs[i].exp[31-8*j -: 8]));
            nr = rd_log.size() - rd_base;
            chk($sformatf("vec%0d_rd_count", i), 32'(nr), 32'(vecs[i].exp_rd));
            for (int j = 0; j < nr; j++)
                chk($sformatf("vec%0d_rd_addr%0d", i, j), 32'(rd_log[rd_base+j]), 32'(j));
            chk($sformatf("vec%0d_a", i), 32'(a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_uploading", i), 32'(uploading), 32'd1);
            flush();
        end

        // The load at the end of the first transfer's data byte already consumes RAM[1].
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        size = 16'd10;
        run(C_RX, 8'h01, 1, 0);
        run(C_DAT, 8'h00, 1, 0);
        chk("split1_nbytes", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("split1_byte", 32'(rx_q[0]), 32'(mem[0]));
        flush();
        run(C_DAT, 8'h00, 1, 0);
        chk("split2_nbytes", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("split2_byte", 32'(rx_q[0]), 32'(mem[2]));
        chk("split2_a", 32'(a), 32'd4);
        flush();

        run(C_RX, 8'h01, 1, 0);
        run(C_DAT, 8'h00, 0, 3);
        compare_state("abort");
        run(C_DAT, 8'h00, 1, 0);
        chk("abort_next_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'(mem[1]));
        compare_state("abort_next");
        run(C_RX, 8'h00, 1, 0);
        run(C_DAT, 8'h00, 2, 0);
        chk("stop_uploading", 32'(uploading), 32'd0);
        compare_state("stopped");

        size = 16'd8;
        run(C_RX, 8'h01, 1, 0);
        compare_state("pre_reset");
        ss = 1'b0;
        wait_half();
        spi_bits(C_DAT, 8, b, ones);
        spi_bits(8'hFF, 3, b, ones);
        reset_n = 1'b0;
        #1;
        chk("midrst_uploading", 32'(uploading), 32'd0);
        chk("midrst_rd", 32'(rd), 32'd0);
        chk("midrst_a", 32'(a), 32'd0);
        chk("midrst_sdo", 32'(sdo), 32'd0);
        chk("midrst_sdo_oe", 32'(sdo_oe), 32'd0);
        ss  = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        m_up   = 1'b0;
        m_addr = 16'd0;
        m_end  = 16'd0;
        flush();
        run(C_DAT, 8'h00, 2, 0);
        compare_state("after_reset");
        run(C_RX, 8'h01, 1, 0);
        run(C_DAT, 8'h00, 2, 0);
        compare_state("restart");

        jitter_on = 1'b1;
        for (int it = 0; it < 24; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
                size = 16'($urandom_range(0, 12));
                run(C_RX, 8'($urandom_range(1, 255)), 1, 0);
            end else if (r == 3) begin
                run(C_RX, 8'h00, 1, 0);
            end else if (r == 4) begin
                run(C_DL, 8'($urandom), int'($urandom_range(1, 3)), 0);
            end else begin
                run(C_DAT, 8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
            end
            compare_state($sformatf("rand%0d", it));
        end

        chk("rd_back_to_back", 32'(b2b_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
